// File: rtl/pcileech_shadow_ctrl_pkg.sv
// Shared types for the shadow config-space controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcileech_shadow_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_FLG = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR    = 3'd3,
        FLG   = 3'd4,
        DRAIN = 3'd5
    } state_e;

    // One packed response: even DW address of the lo half plus both DWs.
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] hi;
        logic [31:0] lo;
    } rsp_word;

    localparam int unsigned MAX_PAIRS = 512;

    // Burst length field of 0 encodes the full 512-pair window.
    function automatic logic [9:0] pairs_from_len(input logic [8:0] len);
        return (len == 9'd0) ? 10'(MAX_PAIRS) : {1'b0, len};
    endfunction

endpackage

// File: rtl/pcileech_shadow_ctrl_rspfifo.sv
// Single-clock first-word-fall-through FIFO of packed response words.
// Latency: a pushed word is visible on dat_o the cycle after the push.
// Backpressure: none upstream; caller must never push when full (asserted).
//
// Ports: clk_i/rst_i (sync active-high), push_i/push_dat_i write side,
// pop_i/vld_o/dat_o read side, count_o current occupancy (0..DEPTH).
module pcileech_shadow_ctrl_rspfifo
    import pcileech_shadow_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  rsp_word                  push_dat_i,
    input  logic                     pop_i,
    output logic                     vld_o,
    output rsp_word                  dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    rsp_word     mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        empty;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push_i && (!full || do_pop);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign vld_o   = !empty;
    assign dat_o   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/pcileech_shadow_cfg_ctrl.sv
// Host-command initiator for the shadow config space: burst read, DW write, flag set.
// Latency: requests registered 1 cycle after acceptance/issue; response word FWFT 1 cycle after hi DW.
// Backpressure: shadow tx path cannot stall, so read pairs are issued only against free FIFO credit.
//
// Ports: clk_sys/rst (sync active-high); cmd_* host command (valid/ready);
// sh_rx_* registered shadow requests; sh_cfgtlp_* registered flags;
// sh_tx_* shadow responses (never stall); rsp_* packed 64-bit responses
// (valid/ready); busy = not idle; err_timeout sticky response timeout.
// Optional: define SHADOW_CTRL_TIMEOUT_EN to abort bursts whose responses stop
// arriving for RSP_TIMEOUT cycles; otherwise err_timeout is tied 0.
module pcileech_shadow_cfg_ctrl
    import pcileech_shadow_ctrl_pkg::*;
#(
    parameter int unsigned OUT_DEPTH   = 16,
    parameter int unsigned RSP_TIMEOUT = 1024
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [9:0]  cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_data,
    output logic        sh_rx_rden,
    output logic        sh_rx_wren,
    output logic        sh_rx_addr_lo,
    output logic [9:0]  sh_rx_addr,
    output logic [3:0]  sh_rx_be,
    output logic [31:0] sh_rx_data,
    output logic        sh_cfgtlp_en,
    output logic        sh_cfgtlp_wren,
    output logic        sh_cfgtlp_zero,
    input  logic        sh_tx_valid,
    input  logic        sh_tx_addr_lo,
    input  logic [9:0]  sh_tx_addr,
    input  logic [31:0] sh_tx_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [9:0]  rsp_addr,
    output logic        busy,
    output logic        err_timeout
);

    localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(OUT_DEPTH);

    state_e      state_q;
    logic [9:0]  a_q;
    logic [9:0]  n_q;
    logic [2:0]  flg_q;
    logic        rden_q;
    logic        wren_q;
    logic        addr_lo_q;
    logic [9:0]  addr_q;
    logic [3:0]  be_q;
    logic [31:0] data_q;
    logic        en_q;
    logic        fwren_q;
    logic        zero_q;

    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic          lo_vld_q;
    logic [31:0]   lo_data_q;
    logic [9:0]    lo_addr_q;

    logic          cmd_acc;
    logic          credit_ok;
    logic          inflight_inc;
    logic          rsp_take;
    logic          lo_set;
    logic          pair_push;
    logic          tmo_fire;
    rsp_word       push_dat;
    rsp_word       head_dat;
    logic [CW-1:0] fifo_cnt;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cmd_acc   = cmd_valid && (state_q == IDLE);

    // Every pair already requested or buffered holds one FIFO slot.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < CREDIT_LIM;

    assign sh_rx_rden     = rden_q;
    assign sh_rx_wren     = wren_q;
    assign sh_rx_addr_lo  = addr_lo_q;
    assign sh_rx_addr     = addr_q;
    assign sh_rx_be       = be_q;
    assign sh_rx_data     = data_q;
    assign sh_cfgtlp_en   = en_q;
    assign sh_cfgtlp_wren = fwren_q;
    assign sh_cfgtlp_zero = zero_q;

    // ---------------- command FSM with registered request outputs ----------
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            n_q       <= '0;
            flg_q     <= '0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            addr_lo_q <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            fwren_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle; be/data only carry meaning on writes.
            rden_q <= 1'b0;
            wren_q <= 1'b0;
            be_q   <= '0;
            data_q <= '0;
            if (tmo_fire) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_acc) begin
                            case (op_e'(cmd_op))
                                OP_RD: begin
                                    a_q     <= {cmd_addr[9:1], 1'b0};
                                    n_q     <= pairs_from_len(cmd_len);
                                    state_q <= RD_LO;
                                end
                                OP_WR: begin
                                    wren_q    <= 1'b1;
                                    addr_lo_q <= 1'b0;
                                    addr_q    <= cmd_addr;
                                    be_q      <= cmd_be;
                                    data_q    <= cmd_data;
                                    state_q   <= WR;
                                end
                                OP_FLG: begin
                                    flg_q   <= cmd_data[2:0];
                                    state_q <= FLG;
                                end
                                default: ;
                            endcase
                        end
                    end
                    RD_LO: begin
                        if (credit_ok) begin
                            rden_q    <= 1'b1;
                            addr_lo_q <= 1'b0;
                            addr_q    <= a_q;
                            state_q   <= RD_HI;
                        end
                    end
                    RD_HI: begin
                        // hi always follows lo so the pair is back-to-back
                        rden_q    <= 1'b1;
                        addr_lo_q <= 1'b1;
                        addr_q    <= a_q + 10'd1;
                        a_q       <= a_q + 10'd2;
                        n_q       <= n_q - 10'd1;
                        state_q   <= (n_q == 10'd1) ? DRAIN : RD_LO;
                    end
                    WR: state_q <= IDLE;
                    FLG: begin
                        {zero_q, fwren_q, en_q} <= flg_q;
                        state_q <= IDLE;
                    end
                    DRAIN: begin
                        if (inflight_q == '0) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // ---------------- response assembly ------------------------------------
    assign inflight_inc = (state_q == RD_HI) && !tmo_fire;
    // Nothing is expected while no pair is outstanding.
    assign rsp_take     = sh_tx_valid && (inflight_q != '0);
    assign lo_set       = rsp_take && !sh_tx_addr_lo;
    assign pair_push    = rsp_take && sh_tx_addr_lo && lo_vld_q;
    assign push_dat     = '{addr: lo_addr_q, hi: sh_tx_data, lo: lo_data_q};

    always_comb begin
        inflight_d = inflight_q;
        if (tmo_fire) begin
            inflight_d = '0;
        end else begin
            case ({inflight_inc, pair_push})
                2'b10:   inflight_d = inflight_q + 1'b1;
                2'b01:   inflight_d = inflight_q - 1'b1;
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            inflight_q <= '0;
            lo_vld_q   <= 1'b0;
            lo_data_q  <= '0;
            lo_addr_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (tmo_fire) begin
                lo_vld_q <= 1'b0;
            end else if (lo_set) begin
                lo_vld_q  <= 1'b1;
                lo_data_q <= sh_tx_data;
                lo_addr_q <= sh_tx_addr;
            end else if (pair_push) begin
                lo_vld_q <= 1'b0;
            end
        end
    end

    pcileech_shadow_ctrl_rspfifo #(
        .DEPTH (OUT_DEPTH)
    ) u_rspfifo (
        .clk_i      (clk_sys),
        .rst_i      (rst),
        .push_i     (pair_push),
        .push_dat_i (push_dat),
        .pop_i      (rsp_ready),
        .vld_o      (rsp_valid),
        .dat_o      (head_dat),
        .count_o    (fifo_cnt)
    );

    assign rsp_data = {head_dat.hi, head_dat.lo};
    assign rsp_addr = head_dat.addr;

    // ---------------- optional response timeout ----------------------------
`ifdef SHADOW_CTRL_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(RSP_TIMEOUT - 1);

    logic [15:0] tmo_cnt_q;
    logic        err_timeout_q;

    assign tmo_fire    = (inflight_q != '0) && !sh_tx_valid && (tmo_cnt_q == TMO_LAST);
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            // Only silence with pairs outstanding counts toward the abort.
            if (tmo_fire || sh_tx_valid || (inflight_q == '0)) tmo_cnt_q <= '0;
            else                                               tmo_cnt_q <= tmo_cnt_q + 16'd1;
            if (tmo_fire)     err_timeout_q <= 1'b1;
            else if (cmd_acc) err_timeout_q <= 1'b0;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    a_params_ok: assert property (@(posedge clk_sys)
        (OUT_DEPTH >= 4) && ((OUT_DEPTH & (OUT_DEPTH - 1)) == 0) &&
        (RSP_TIMEOUT >= 1) && (RSP_TIMEOUT <= 65535));

    a_one_strobe: assert property (@(posedge clk_sys) disable iff (rst)
        !(rden_q && wren_q));

endmodule

// File: tb/tb_pcileech_shadow_cfg_ctrl.sv
module tb_pcileech_shadow_cfg_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [9:0]  cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic [3:0]  cmd_be = '0;
    logic [31:0] cmd_data = '0;
    logic        sh_rx_rden, sh_rx_wren, sh_rx_addr_lo;
    logic [9:0]  sh_rx_addr;
    logic [3:0]  sh_rx_be;
    logic [31:0] sh_rx_data;
    logic        sh_cfgtlp_en, sh_cfgtlp_wren, sh_cfgtlp_zero;
    logic        sh_tx_valid = 1'b0;
    logic        sh_tx_addr_lo = 1'b0;
    logic [9:0]  sh_tx_addr = '0;
    logic [31:0] sh_tx_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic [9:0]  rsp_addr;
    logic        busy;
    logic        err_timeout;

    always #5 clk_sys = ~clk_sys;

    pcileech_shadow_cfg_ctrl #(
        .OUT_DEPTH   (16),
        .RSP_TIMEOUT (32)
    ) dut (
        .clk_sys        (clk_sys),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_be         (cmd_be),
        .cmd_data       (cmd_data),
        .sh_rx_rden     (sh_rx_rden),
        .sh_rx_wren     (sh_rx_wren),
        .sh_rx_addr_lo  (sh_rx_addr_lo),
        .sh_rx_addr     (sh_rx_addr),
        .sh_rx_be       (sh_rx_be),
        .sh_rx_data     (sh_rx_data),
        .sh_cfgtlp_en   (sh_cfgtlp_en),
        .sh_cfgtlp_wren (sh_cfgtlp_wren),
        .sh_cfgtlp_zero (sh_cfgtlp_zero),
        .sh_tx_valid    (sh_tx_valid),
        .sh_tx_addr_lo  (sh_tx_addr_lo),
        .sh_tx_addr     (sh_tx_addr),
        .sh_tx_data     (sh_tx_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_addr       (rsp_addr),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    // ---------------- shadow model: 1-cycle echo, data = address ----------
    logic        model_en = 1'b1;
    logic        inj_vld = 1'b0;
    logic        inj_lo = 1'b0;
    logic [9:0]  inj_addr = '0;
    logic [31:0] inj_data = '0;

    always @(posedge clk_sys) begin
        sh_tx_valid   <= (model_en && sh_rx_rden) || inj_vld;
        sh_tx_addr_lo <= inj_vld ? inj_lo   : sh_rx_addr_lo;
        sh_tx_addr    <= inj_vld ? inj_addr : sh_rx_addr;
        sh_tx_data    <= inj_vld ? inj_data : {22'd0, sh_rx_addr};
    end

    // ---------------- monitor: request and response logs -------------------
    typedef struct packed {
        logic        wr;
        logic        hi;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;
    typedef struct packed {
        logic [9:0]  addr;
        logic [63:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   adj_err = 0;
    int   both_err = 0;
    int   rdbe_err = 0;
    logic prev_lo = 1'b0;

    always @(posedge clk_sys) begin
        if (sh_rx_rden || sh_rx_wren)
            req_q.push_back('{wr: sh_rx_wren, hi: sh_rx_addr_lo, addr: sh_rx_addr,
                              be: sh_rx_be, data: sh_rx_data});
        if (sh_rx_rden && sh_rx_addr_lo && !prev_lo) adj_err++;
        if (sh_rx_rden && sh_rx_wren) both_err++;
        if (sh_rx_rden && (sh_rx_be != 4'h0)) rdbe_err++;
        prev_lo = sh_rx_rden && !sh_rx_addr_lo;
        if (rsp_valid && rsp_ready) rsp_q.push_back('{addr: rsp_addr, data: rsp_data});
    end

    // ---------------- checking helpers --------------------------------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Returns 1 time unit after the edge on which the command was accepted.
    task automatic send(input logic [1:0] op, input logic [9:0] a, input logic [8:0] len,
                        input logic [3:0] be, input logic [31:0] d);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_addr = a; cmd_len = len; cmd_be = be; cmd_data = d;
        while (!cmd_ready && w < 3000) begin
            step();
            w++;
        end
        if (w >= 3000) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int w;
        w = 0;
        while ((busy || rsp_valid) && w < limit) begin
            step();
            w++;
        end
        chk(nm, 64'(busy || rsp_valid), 64'd0);
    endtask

    task automatic inject(input logic lo_hi, input logic [9:0] a, input logic [31:0] d);
        inj_vld = 1'b1; inj_lo = lo_hi; inj_addr = a; inj_data = d;
        step();
        inj_vld = 1'b0;
    endtask

    function automatic int count_reqs(input int from, input logic want_wr, input logic only_hi);
        int n;
        n = 0;
        for (int k = from; k < req_q.size(); k++)
            if (req_q[k].wr == want_wr && (!only_hi || req_q[k].hi)) n++;
        return n;
    endfunction

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [8:0]  len;
        logic [3:0]  be;
        logic [31:0] data;
        int          nrd;
        int          nwr;
        logic [9:0]  first;
        logic [9:0]  last;
        int          nrsp;
        logic [9:0]  r0a;
        logic [63:0] r0d;
        logic [9:0]  rla;
        logic [63:0] rld;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int r0, p0, n, nrd, nwr, derr;
        vec_t v;

        vecs[0] = '{2'b10, 10'h004, 9'd0, 4'hF, 32'hDEADBEEF, 0, 1, 10'h004, 10'h004,
                    0, 10'h000, 64'h0, 10'h000, 64'h0};
        vecs[1] = '{2'b01, 10'h000, 9'd2, 4'h0, 32'h0, 4, 0, 10'h000, 10'h003,
                    2, 10'h000, 64'h00000001_00000000, 10'h002, 64'h00000003_00000002};
        vecs[2] = '{2'b01, 10'h3FE, 9'd2, 4'h0, 32'h0, 4, 0, 10'h3FE, 10'h001,
                    2, 10'h3FE, 64'h000003FF_000003FE, 10'h000, 64'h00000001_00000000};
        vecs[3] = '{2'b01, 10'h011, 9'd1, 4'h0, 32'h0, 2, 0, 10'h010, 10'h011,
                    1, 10'h010, 64'h00000011_00000010, 10'h010, 64'h00000011_00000010};
        vecs[4] = '{2'b01, 10'h100, 9'd3, 4'h0, 32'h0, 6, 0, 10'h100, 10'h105,
                    3, 10'h100, 64'h00000101_00000100, 10'h104, 64'h00000105_00000104};
        vecs[5] = '{2'b00, 10'h0AA, 9'd5, 4'h0, 32'h0, 0, 0, 10'h000, 10'h000,
                    0, 10'h000, 64'h0, 10'h000, 64'h0};
        vecs[6] = '{2'b10, 10'h3FF, 9'd0, 4'h3, 32'h12345678, 0, 1, 10'h3FF, 10'h3FF,
                    0, 10'h000, 64'h0, 10'h000, 64'h0};

        // ---- reset state ----
        repeat (3) step();
        rst = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'({sh_rx_rden, sh_rx_wren, sh_rx_addr_lo, sh_rx_addr, sh_rx_be}), 64'd0);
        chk("rst_wdata", 64'(sh_rx_data), 64'd0);
        chk("rst_flags", 64'({sh_cfgtlp_en, sh_cfgtlp_wren, sh_cfgtlp_zero}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_addr}), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);

        // ---- single write: exactly one wren cycle ----
        send(2'b10, 10'h004, 9'd0, 4'hF, 32'hDEADBEEF);
        chk("wr_strobe", 64'({sh_rx_wren, sh_rx_rden}), 64'b10);
        chk("wr_addr", 64'(sh_rx_addr), 64'h004);
        chk("wr_be_data", 64'({sh_rx_be, sh_rx_data}), 64'hF_DEADBEEF);
        chk("wr_busy", 64'(busy), 64'd1);
        step();
        chk("wr_done", 64'({busy, sh_rx_wren}), 64'd0);

        // ---- table-driven commands ----
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            r0 = req_q.size();
            p0 = rsp_q.size();
            send(v.op, v.addr, v.len, v.be, v.data);
            wait_idle($sformatf("v%0d_idle", i), 200);
            repeat (3) step();
            nrd = count_reqs(r0, 1'b0, 1'b0);
            nwr = count_reqs(r0, 1'b1, 1'b0);
            chk($sformatf("v%0d_nrd", i), 64'(nrd), 64'(v.nrd));
            chk($sformatf("v%0d_nwr", i), 64'(nwr), 64'(v.nwr));
            chk($sformatf("v%0d_nrsp", i), 64'(rsp_q.size() - p0), 64'(v.nrsp));
            if (v.nrd + v.nwr > 0 && req_q.size() > r0) begin
                chk($sformatf("v%0d_req_first", i), 64'(req_q[r0].addr), 64'(v.first));
                chk($sformatf("v%0d_req_last", i), 64'(req_q[req_q.size()-1].addr), 64'(v.last));
            end
            if (v.nwr > 0 && req_q.size() > r0)
                chk($sformatf("v%0d_wr_be_data", i),
                    64'({req_q[req_q.size()-1].be, req_q[req_q.size()-1].data}),
                    64'({v.be, v.data}));
            if (v.nrsp > 0 && rsp_q.size() > p0) begin
                chk($sformatf("v%0d_rsp0_addr", i), 64'(rsp_q[p0].addr), 64'(v.r0a));
                chk($sformatf("v%0d_rsp0_data", i), rsp_q[p0].data, v.r0d);
                chk($sformatf("v%0d_rspL_addr", i), 64'(rsp_q[rsp_q.size()-1].addr), 64'(v.rla));
                chk($sformatf("v%0d_rspL_data", i), rsp_q[rsp_q.size()-1].data, v.rld);
            end
        end

        // ---- flag set, then orphan responses are dropped ----
        send(2'b11, 10'h000, 9'd0, 4'h0, 32'h0000_0005);
        step();
        chk("flg_value", 64'({sh_cfgtlp_zero, sh_cfgtlp_wren, sh_cfgtlp_en}), 64'b101);
        chk("flg_busy", 64'(busy), 64'd0);
        p0 = rsp_q.size();
        inject(1'b1, 10'h041, 32'hAAAA_0041);
        repeat (4) step();
        chk("orphan_hi_drop", 64'(rsp_valid), 64'd0);
        inject(1'b0, 10'h040, 32'hAAAA_0040);
        inject(1'b1, 10'h041, 32'hAAAA_0041);
        repeat (4) step();
        chk("idle_pair_drop", 64'(rsp_q.size() - p0), 64'd0);
        chk("flg_held", 64'({sh_cfgtlp_zero, sh_cfgtlp_wren, sh_cfgtlp_en}), 64'b101);

        // ---- credit stall with consumer blocked, 512-pair burst ----
        rsp_ready = 1'b0;
        r0 = req_q.size();
        p0 = rsp_q.size();
        send(2'b01, 10'h000, 9'd0, 4'h0, 32'h0);
        repeat (200) step();
        chk("bp_pairs_issued", 64'(count_reqs(r0, 1'b0, 1'b1)), 64'd16);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_head", 64'({rsp_valid, rsp_addr}), 64'({1'b1, 10'h000}));
        rsp_ready = 1'b1;
        wait_idle("bp_idle", 5000);
        repeat (3) step();
        chk("bp_nreq", 64'(req_q.size() - r0), 64'd1024);
        chk("bp_nrsp", 64'(rsp_q.size() - p0), 64'd512);
        derr = 0;
        for (int k = 0; k < 512 && (p0 + k) < rsp_q.size(); k++) begin
            logic [9:0] ea;
            ea = 10'(2 * k);
            if (rsp_q[p0+k].addr != ea ||
                rsp_q[p0+k].data != {22'd0, ea + 10'd1, 22'd0, ea}) derr++;
        end
        chk("bp_word_errors", 64'(derr), 64'd0);

        // ---- silent shadow ----
        model_en = 1'b0;
        r0 = req_q.size();
`ifdef SHADOW_CTRL_TIMEOUT_EN
        send(2'b01, 10'h020, 9'd1, 4'h0, 32'h0);
        n = 0;
        while (!err_timeout && n < 100) begin
            step();
            n++;
        end
        chk("tmo_latency", 64'(n), 64'd34);
        chk("tmo_state_idle", 64'({busy, cmd_ready}), 64'b01);
        chk("tmo_nreq", 64'(req_q.size() - r0), 64'd2);
        inject(1'b0, 10'h020, 32'h20);
        inject(1'b1, 10'h021, 32'h21);
        repeat (4) step();
        chk("tmo_late_drop", 64'(rsp_valid), 64'd0);
        chk("tmo_sticky", 64'(err_timeout), 64'd1);
        send(2'b00, 10'h000, 9'd0, 4'h0, 32'h0);
        chk("tmo_clear", 64'(err_timeout), 64'd0);
`else
        send(2'b01, 10'h020, 9'd1, 4'h0, 32'h0);
        repeat (100) step();
        chk("silent_drain_busy", 64'(busy), 64'd1);
        chk("silent_no_err", 64'(err_timeout), 64'd0);
        chk("silent_nreq", 64'(req_q.size() - r0), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // ---- reset in the middle of a burst ----
        send(2'b01, 10'h000, 9'd4, 4'h0, 32'h0);
        repeat (3) step();
        chk("midrst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        r0 = req_q.size();
        repeat (20) step();
        chk("midrst_no_req", 64'(req_q.size() - r0), 64'd0);
        chk("midrst_idle", 64'({busy, cmd_ready, rsp_valid}), 64'b010);
        chk("midrst_flags", 64'({sh_cfgtlp_zero, sh_cfgtlp_wren, sh_cfgtlp_en}), 64'd0);

        // ---- recovery after reset ----
        model_en = 1'b1;
        p0 = rsp_q.size();
        send(2'b01, 10'h200, 9'd1, 4'h0, 32'h0);
        wait_idle("rec_idle", 200);
        repeat (3) step();
        chk("rec_nrsp", 64'(rsp_q.size() - p0), 64'd1);
        if (rsp_q.size() > p0)
            chk("rec_rsp", 64'({rsp_q[p0].addr, rsp_q[p0].data[41:32], rsp_q[p0].data[9:0]}),
                64'({10'h200, 10'h201, 10'h200}));

        // ---- protocol invariants over the whole run ----
        chk("pair_adjacent_errors", 64'(adj_err), 64'd0);
        chk("rden_wren_overlap", 64'(both_err), 64'd0);
        chk("read_be_nonzero", 64'(rdbe_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
